// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide add/subtract sequenced one nibble per cycle through an external CLA4
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   start_i                 request, accepted only while ready_o=1
//   op_a_i, op_b_i, sub_i   operands and mode (0 = A+B, 1 = A-B), sampled on accept
//   ready_o, busy_o, done_o IDLE / RUN / one-cycle DONE indicators
//   sum_o, cout_o, ovf_o    result, final carry (sub: 1 = no borrow), signed overflow
//   add_a_o, add_b_o, add_ci_o  nibble operands and carry-in towards the CLA4
//   add_s_i, add_co_i       CLA4 sum and carry-out
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [4*NIBBLES-1:0]   op_a_i,
  input  logic [4*NIBBLES-1:0]   op_b_i,
  input  logic                   sub_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NIBBLES-1:0]   sum_o,
  output logic                   cout_o,
  output logic                   ovf_o,
  output logic [3:0]             add_a_o,
  output logic [3:0]             add_b_o,
  output logic                   add_ci_o,
  input  logic [3:0]             add_s_i,
  input  logic                   add_co_i
);
  localparam int W = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           cout_q, cout_d, ovf_q, ovf_d;
  logic           run, last;

  assign run      = state_q == RUN;
  assign last     = idx_q == LAST;
  assign ready_o  = state_q == IDLE;
  assign busy_o   = run;
  assign done_o   = state_q == DONE;
  assign sum_o    = sum_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;
  assign add_a_o  = run ? a_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign add_b_o  = run ? b_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign add_ci_o = run & carry_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start_i) begin
      state_d = RUN;
      a_d     = op_a_i;
      b_d     = sub_i ? ~op_b_i : op_b_i;
      carry_d = sub_i;
      idx_d   = '0;
      sum_d   = '0;
    end else if (run) begin
      sum_d[{idx_q, 2'b00} +: 4] = add_s_i;
      carry_d = add_co_i;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) begin
        state_d = DONE;
        cout_d  = add_co_i;
        // carry into the MSB is recovered from the MSB sum bit and its operand bits
        ovf_d   = add_co_i ^ (a_q[W-1] ^ b_q[W-1] ^ add_s_i[3]);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized and directed checks of the nibble-serial add controller against an arithmetic model
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0, rst, start, sub;
  logic [W-1:0] op_a, op_b, sum;
  logic ready, busy, done, cout, ovf, add_ci, add_co;
  logic [3:0] add_a, add_b, add_s;

  int total = 0, passes = 0;

  int m_cyc;
  logic [W-1:0] e_a, e_bv, e_sum;
  logic e_sub, e_cout, e_ovf, p_cout, p_ovf;

  logic [3:0] cap_a [N];
  logic [3:0] cap_b [N];
  logic       cap_c [N];
  logic [3:0] ea [N];
  logic [3:0] eb [N];
  logic       ec [N];
  int ndone;

  always #5 clk = ~clk;

  assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .op_a_i(op_a), .op_b_i(op_b), .sub_i(sub),
    .ready_o(ready), .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout), .ovf_o(ovf),
    .add_a_o(add_a), .add_b_o(add_b), .add_ci_o(add_ci), .add_s_i(add_s), .add_co_i(add_co)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return v[W-1] ? longint'(v) - (64'sd1 <<< W) : longint'(v);
  endfunction

  function automatic longint nib(input logic [W-1:0] v, input int k);
    return longint'((v >> (4 * k)) & 4'hF);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc  <= -1;
      e_sum  <= '0;
      e_cout <= 1'b0;
      e_ovf  <= 1'b0;
      p_cout <= 1'b0;
      p_ovf  <= 1'b0;
    end else if (m_cyc < 0) begin
      if (start) begin
        p_cout <= e_cout;
        p_ovf  <= e_ovf;
        e_a    <= op_a;
        e_bv   <= sub ? ~op_b : op_b;
        e_sub  <= sub;
        e_sum  <= sub ? op_a - op_b : op_a + op_b;
        e_cout <= sub ? (op_a >= op_b) : (longint'(op_a) + longint'(op_b) >= (64'sd1 <<< W));
        e_ovf  <= (sub ? sx(op_a) - sx(op_b) : sx(op_a) + sx(op_b)) >= (64'sd1 <<< (W - 1)) ||
                  (sub ? sx(op_a) - sx(op_b) : sx(op_a) + sx(op_b)) < -(64'sd1 <<< (W - 1));
        m_cyc  <= 0;
      end
    end else if (m_cyc == N) m_cyc <= -1;
    else m_cyc <= m_cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", ready, m_cyc < 0);
      chk("busy", busy, m_cyc >= 0 && m_cyc < N);
      chk("done", done, m_cyc == N);
      if (m_cyc >= 0 && m_cyc < N) begin
        chk("add_a", add_a, nib(e_a, m_cyc));
        chk("add_b", add_b, nib(e_bv, m_cyc));
        chk("add_ci", add_ci, ((longint'(e_a) & ((64'sd1 <<< (4 * m_cyc)) - 1)) +
                               (longint'(e_bv) & ((64'sd1 <<< (4 * m_cyc)) - 1)) + longint'(e_sub)) >>> (4 * m_cyc));
        chk("sum_part", sum, longint'(e_sum) & ((64'sd1 <<< (4 * m_cyc)) - 1));
        chk("cout_hold", cout, p_cout);
        chk("ovf_hold", ovf, p_ovf);
      end else begin
        chk("add_idle", {add_a, add_b, add_ci}, 0);
        chk("sum", sum, e_sum);
        chk("cout", cout, e_cout);
        chk("ovf", ovf, e_ovf);
      end
    end
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      cap_a[k] = add_a; cap_b[k] = add_b; cap_c[k] = add_ci;
      op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    end
    @(negedge clk);
    chk("done_at_latency", done, 1);
  endtask

  task automatic res(input string nm, input longint es, input logic ec_, input logic eo);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, ec_);
    chk({nm, "_ovf"}, ovf, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_outs", {busy, done, cout, ovf, add_a, add_b, add_ci}, 0);
    chk("rst_sum", sum, 0);
    rst = 1'b0;

    op(16'h1234, 16'h4321, 1'b0);
    res("add1", 16'h5555, 0, 0);
    ea = '{4'h4, 4'h3, 4'h2, 4'h1};
    eb = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int k = 0; k < N; k++) begin
      chk("add1_a_seq", cap_a[k], ea[k]);
      chk("add1_b_seq", cap_b[k], eb[k]);
    end

    op(16'hFFFF, 16'h0001, 1'b0);
    res("ripple", 16'h0000, 1, 0);
    ec = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < N; k++) chk("ripple_ci_seq", cap_c[k], ec[k]);

    op(16'h7FFF, 16'h0001, 1'b0);
    res("ovf_add", 16'h8000, 0, 1);

    op(16'h0005, 16'h0007, 1'b1);
    res("sub1", 16'hFFFE, 0, 0);
    chk("sub1_ci0", cap_c[0], 1);
    chk("sub1_b0", cap_b[0], 4'h8);

    op(16'h8000, 16'h0001, 1'b1);
    res("sub_ovf", 16'h7FFF, 1, 1);

    @(negedge clk);
    ndone = 0;
    start = 1'b1;
    for (int i = 0; i < 3 * (N + 2); i++) begin
      op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("held_start_dones", ndone, 3);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom); start = 1'b1;
      if (i % 8 == 0) op_b = op_a;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < N; k++) begin
        @(negedge clk);
        start = 1'($urandom); op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_outs", {busy, done, cout, ovf, add_a, add_b, add_ci}, 0);
    chk("abort_sum", sum, 0);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    rst = 1'b0;
    op(16'h0001, 16'h0001, 1'b0);
    res("after_abort", 16'h0002, 0, 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
